dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 tb/tb_dmem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder with a fixed number of wait states per access.
//   A request is accepted in IDLE. The access then waits WAIT cycles in BUSY,
//   and completes with a single-cycle RESP strobe.
//
// Parameters
//   DEPTH  number of 32-bit words (power of two, 16..1024)
//   WAIT   wait-state cycles per access (0..15)
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous active-low reset
//   req_valid   requester holds a request
//   req_ready   high only in IDLE
//   memwrite    1 = store, 0 = load (sampled on accept)
//   addr        byte address; word index = addr[log2(DEPTH)+1:2]
//   writedata   store data (sampled on accept)
//   readdata    load result while resp_valid=1, otherwise 0
//   resp_valid  one-cycle completion strobe
//   err         misaligned-access flag while resp_valid=1, otherwise 0
//   fsm_state   current FSM state (debug visibility)
//
// Optional feature
//   DMEM_ALIGN_CHECK_EN  when defined, addr[1:0] != 0 suppresses the memory
//                        access and the response reports err=1, readdata=0.
//                        When undefined, err is 0 and addr[1:0] is ignored.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. The requester must hold req_valid and its payload
// stable until that edge. resp_valid is a one-cycle strobe that needs no
// acknowledge.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        resp_valid,
  output logic        err,
  output logic [1:0]  fsm_state
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [3:0]      cnt, cnt_next;

  // Captured request
  logic            wr_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            mis_q;

  // Memory write port
  logic            commit_en;
  logic [AW-1:0]   commit_idx;
  logic [31:0]     commit_data;

  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   idx_in;
  logic            mis_in;
  logic            unused_addr_bits;

  assign idx_in = addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_in = (addr[1:0] != 2'b00);
`else
  assign mis_in = 1'b0;
`endif

  // Upper address bits are deliberately ignored so addresses wrap.
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  assign fsm_state = state;

  // Next-state and output logic
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    readdata    = 32'h0;
    err         = 1'b0;
    commit_en   = 1'b0;
    commit_idx  = idx_q;
    commit_data = wdata_q;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT == 0) begin
            // Zero wait states: the accept edge is also the edge entering
            // RESP, so the store commits straight from the request inputs.
            state_next  = RESP;
            cnt_next    = 4'd0;
            commit_en   = memwrite & ~mis_in;
            commit_idx  = idx_in;
            commit_data = writedata;
          end else begin
            state_next = BUSY;
            cnt_next   = WAIT_CNT;
          end
        end
      end

      BUSY: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = RESP;
          commit_en  = wr_q & ~mis_q;
        end
      end

      RESP: begin
        resp_valid = 1'b1;
        err        = mis_q;
        // Stores and suppressed accesses return zero.
        readdata   = (wr_q || mis_q) ? 32'h0 : mem[idx_q];
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // State, counter and request capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == IDLE && req_valid) begin
        wr_q    <= memwrite;
        idx_q   <= idx_in;
        wdata_q <= writedata;
        mis_q   <= mis_in;
      end
    end
  end

  // Memory array is not reset; contents survive reset. The reset term keeps a
  // request presented during reset from writing.
  always_ff @(posedge clk) begin
    if (commit_en && reset) begin
      mem[commit_idx] <= commit_data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder (DEPTH=64, WAIT=2).
//   The reference model is a word array indexed by (addr/4) mod DEPTH, updated
//   only when a store is aligned (or alignment is not checked) and not aborted.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WAIT  = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        resp_valid;
  logic        err;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT(WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .memwrite   (memwrite),
    .addr       (addr),
    .writedata  (writedata),
    .readdata   (readdata),
    .resp_valid (resp_valid),
    .err        (err),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit misaligned(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: apply one completed access and queue its response.
  function automatic void model_access(input logic wr, input logic [31:0] a,
                                       input logic [31:0] d);
    int w;
    w = int'((a / 4) % DEPTH);
    if (misaligned(a)) begin
      exp_q.push_back(32'h0);
      exp_err_q.push_back(1'b1);
    end else if (wr) begin
      ref_mem[w] = d;
      exp_q.push_back(32'h0);
      exp_err_q.push_back(1'b0);
    end else begin
      exp_q.push_back(ref_mem[w]);
      exp_err_q.push_back(1'b0);
    end
  endfunction

  // ---------------- driver ----------------
  // One complete access: present, accept, wait, check response.
  task automatic do_access(input string tag, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
    int lat;
    bit got;
    bit ready_in_busy;
    logic [31:0] rd_seen;
    logic        err_seen;
    model_access(wr, a, d);
    @(negedge clk);
    req_valid = 1'b1;
    memwrite  = wr;
    addr      = a;
    writedata = d;
    check({"ready_", tag}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);                      // accept edge
    @(negedge clk);
    req_valid = 1'b0;
    memwrite  = ~wr;                     // scramble payload after accept
    addr      = $urandom;
    writedata = $urandom;
    lat = 1;
    got = 1'b0;
    ready_in_busy = 1'b0;
    rd_seen  = 32'h0;
    err_seen = 1'b0;
    while (lat <= 30) begin
      if (resp_valid) begin
        got      = 1'b1;
        rd_seen  = readdata;
        err_seen = err;
        break;
      end
      if (req_ready) ready_in_busy = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({"resp_seen_", tag}, {31'h0, got}, 32'h1);
    check({"busy_ready_", tag}, {31'h0, ready_in_busy}, 32'h0);
    if (got) begin
      check({"latency_", tag}, 32'(lat), 32'(WAIT + 1));
      check({"rdata_", tag}, rd_seen, exp_q.pop_front());
      check({"err_", tag}, {31'h0, err_seen}, {31'h0, exp_err_q.pop_front()});
      @(negedge clk);
      check({"strobe_len_", tag}, {31'h0, resp_valid}, 32'h0);
    end else begin
      void'(exp_q.pop_front());
      void'(exp_err_q.pop_front());
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] rv_mask, rr_mask, rv_exp, rr_exp;
    logic [31:0] rd_cont [2];
    int          nresp;
    int          rcnt;
    logic [31:0] ra, rdat;
    logic        rw;

    reset     = 1'b0;
    req_valid = 1'b0;
    memwrite  = 1'b0;
    addr      = 32'h0;
    writedata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", readdata, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_ready", {31'h0, req_ready}, 32'h1);
    check("rel_resp", {31'h0, resp_valid}, 32'h0);
    check("rel_rdata", readdata, 32'h0);
    check("rel_err", {31'h0, err}, 32'h0);

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++) begin
      do_access("init", 1'b1, 32'(i * 4), $urandom);
    end

    // Store then load, same address
    do_access("st_10", 1'b1, 32'h10, 32'h0000000F);
    do_access("ld_10", 1'b0, 32'h10, 32'h0);

    // Address wrap: 0x100 aliases word 0
    do_access("st_100", 1'b1, 32'h100, 32'h0000000A);
    do_access("ld_0", 1'b0, 32'h0, 32'h0);

    // Continuous request: two back-to-back loads of 0x10
    model_access(1'b0, 32'h10, 32'h0);
    model_access(1'b0, 32'h10, 32'h0);
    @(negedge clk);
    req_valid = 1'b1;
    memwrite  = 1'b0;
    addr      = 32'h10;
    writedata = 32'h0;
    rv_mask = '0;
    rr_mask = '0;
    rv_exp  = '0;
    rr_exp  = '0;
    nresp   = 0;
    rv_exp[WAIT + 1]       = 1'b1;
    rv_exp[2 * WAIT + 3]   = 1'b1;
    rr_exp[WAIT + 2]       = 1'b1;
    rr_exp[2 * (WAIT + 2)] = 1'b1;
    for (int k = 1; k <= 2 * (WAIT + 2); k++) begin
      @(negedge clk);
      rv_mask[k] = resp_valid;
      rr_mask[k] = req_ready;
      if (resp_valid && nresp < 2) begin
        rd_cont[nresp] = readdata;
        nresp++;
      end
    end
    req_valid = 1'b0;
    check("cont_resp_pattern", {16'h0, rv_mask}, {16'h0, rv_exp});
    check("cont_ready_pattern", {16'h0, rr_mask}, {16'h0, rr_exp});
    check("cont_resp_count", 32'(nresp), 32'd2);
    check("cont_rdata0", rd_cont[0], exp_q.pop_front());
    check("cont_rdata1", rd_cont[1], exp_q.pop_front());
    void'(exp_err_q.pop_front());
    void'(exp_err_q.pop_front());

    // Reset during BUSY aborts a store
    do_access("st_20", 1'b1, 32'h20, 32'h3);
    @(negedge clk);
    req_valid = 1'b1;
    memwrite  = 1'b1;
    addr      = 32'h20;
    writedata = 32'h5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    memwrite  = 1'b0;
    reset     = 1'b0;
    #1;
    check("abort_ready", {31'h0, req_ready}, 32'h1);
    check("abort_resp", {31'h0, resp_valid}, 32'h0);
    check("abort_rdata", readdata, 32'h0);
    check("abort_err", {31'h0, err}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) rcnt++;
    end
    check("abort_no_resp", 32'(rcnt), 32'd0);
    do_access("ld_20", 1'b0, 32'h20, 32'h0);

    // Misaligned load
    do_access("ld_12", 1'b0, 32'h12, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      rw   = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rdat = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      do_access("rand", rw, ra, rdat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
